// File: rtl/dm_cache_ctrl_if.sv
// Requester and refill-memory signals of the shared direct-mapped cache controller.
// hit_count/miss_count exist only when DMC_STATS_EN is defined.
interface dm_cache_ctrl_if;
  logic [1:0]  req;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
`ifdef DMC_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport master (output req, addr0, addr1, mem_valid, mem_rdata,
                  input  ack, rdata, mem_req, mem_addr, hit_count, miss_count);
  modport slave  (input  req, addr0, addr1, mem_valid, mem_rdata,
                  output ack, rdata, mem_req, mem_addr, hit_count, miss_count);
`else
  modport master (output req, addr0, addr1, mem_valid, mem_rdata,
                  input  ack, rdata, mem_req, mem_addr);
  modport slave  (input  req, addr0, addr1, mem_valid, mem_rdata,
                  output ack, rdata, mem_req, mem_addr);
`endif
endinterface

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache shared by two round-robin requesters, burst refill on miss.
// Optional hit/miss statistics are enabled with the DMC_STATS_EN macro.
module dm_cache_ctrl #(
  parameter int unsigned INDEX_W  = 8,
  parameter int unsigned OFFSET_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  dm_cache_ctrl_if.slave bus
);

  localparam int unsigned LINES = 1 << INDEX_W;
  localparam int unsigned WORDS = 1 << OFFSET_W;
  localparam int unsigned TAG_W = 32 - INDEX_W - OFFSET_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [31:0]          addr_q;
  logic                 gnt_q;
  logic                 last_grant_q;
  logic [OFFSET_W-1:0]  beat_q;
  logic [LINES-1:0]     valid_q;
  logic [1:0]           ack_q;
  logic [31:0]          rdata_q;
  logic                 mem_req_q;
  logic [31:0]          mem_addr_q;

  logic [TAG_W-1:0]     tag_ram  [LINES];
  logic [31:0]          data_ram [LINES*WORDS];

  logic [TAG_W-1:0]     tag_f;
  logic [INDEX_W-1:0]   idx_f;
  logic [OFFSET_W-1:0]  off_f;
  logic                 lookup_hit;
  logic                 take, gnt_sel, hit_ev, miss_ev, beat_wr, last_beat, resp;

  assign tag_f      = addr_q[31 -: TAG_W];
  assign idx_f      = addr_q[OFFSET_W +: INDEX_W];
  assign off_f      = addr_q[OFFSET_W-1:0];
  assign lookup_hit = valid_q[idx_f] && (tag_ram[idx_f] == tag_f);
  assign last_beat  = beat_wr && (&beat_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus one-cycle control strobes for the datapath.
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    gnt_sel = 1'b0;
    hit_ev  = 1'b0;
    miss_ev = 1'b0;
    beat_wr = 1'b0;
    resp    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          take    = 1'b1;
          gnt_sel = (&bus.req) ? ~last_grant_q : bus.req[1];
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (lookup_hit) begin
          hit_ev  = 1'b1;
          state_d = S_RESP;
        end else begin
          miss_ev = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        if (bus.mem_valid) begin
          beat_wr = 1'b1;
          if (&beat_q) state_d = S_RESP;
        end
      end
      S_RESP: begin
        resp    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Storage arrays carry no reset; line validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (beat_wr)   data_ram[{idx_f, beat_q}] <= bus.mem_rdata;
    if (last_beat) tag_ram[idx_f]            <= tag_f;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      beat_q       <= '0;
      valid_q      <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      ack_q     <= '0;
      // Rises one cycle into REFILL, falls with the final beat.
      mem_req_q <= (state_q == S_REFILL) && !last_beat;
      if (take) begin
        addr_q <= gnt_sel ? bus.addr1 : bus.addr0;
        gnt_q  <= gnt_sel;
      end
      if (miss_ev) mem_addr_q <= {tag_f, idx_f, OFFSET_W'(0)};
      if (beat_wr) beat_q <= beat_q + OFFSET_W'(1);
      if (last_beat) valid_q[idx_f] <= 1'b1;
      if (resp) begin
        ack_q        <= {gnt_q, ~gnt_q};
        rdata_q      <= data_ram[{idx_f, off_f}];
        last_grant_q <= gnt_q;
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;

`ifdef DMC_STATS_EN
  logic [31:0] hit_q, miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (hit_ev)  hit_q  <= hit_q + 32'd1;
      if (miss_ev) miss_q <= miss_q + 32'd1;
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: two requesters plus a burst memory with optional gap.
module tb_dm_cache_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_cache_ctrl_if bus ();

  dm_cache_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          port;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_exp[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int total_beats = 0;
  int mreq_cycles = 0;
  int n_refill    = 0;
  logic mreq_prev = 1'b0;

  int       stall_beat;
  int       stall_len;
  int       gap_left;
  logic [3:0] mem_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Backing store contents: line 0x123 returns 0xA0..0xAF.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    logic [23:0] hi;
    hi = a[27:4] - 24'h000123;
    return {hi, 4'hA, a[3:0]};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_valid) total_beats <= total_beats + 1;

  // Zero-wait burst memory, with an optional gap inserted before beat stall_beat.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_beat <= 4'd0;
      gap_left <= 0;
    end else if (gap_left > 0) begin
      gap_left <= gap_left - 1;
    end else if (bus.mem_valid) begin
      mem_beat <= mem_beat + 4'd1;
      if (int'(mem_beat) + 1 == stall_beat) gap_left <= stall_len;
    end
  end

  always_comb begin
    bus.mem_valid = bus.mem_req && (gap_left == 0);
    bus.mem_rdata = word_of({bus.mem_addr[31:4], mem_beat});
  end

  // Output monitor: refill starts and acks against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_req) mreq_cycles++;
    if (bus.mem_req && !mreq_prev) begin
      n_refill++;
      if (mem_exp.size() == 0) check("refill_expected", 32'(mem_exp.size()), 32'd1);
      else                     check("mem_addr", bus.mem_addr, mem_exp.pop_front());
    end
    mreq_prev = bus.mem_req;
    if (bus.ack != 2'b00) begin
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 32'(bus.ack), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", 32'(bus.ack), (e.port == 1) ? 32'd2 : 32'd1);
        check("rdata", bus.rdata, e.data);
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic start_req(input int port, input logic [31:0] a);
    if (port == 1) bus.addr1 = a;
    else           bus.addr0 = a;
    bus.req[port] = 1'b1;
  endtask

  task automatic wait_ack(input int port);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.ack[port] !== 1'b1 && n < 300);
    check($sformatf("ack%0d_seen", port), 32'(bus.ack[port]), 32'd1);
    bus.req[port] = 1'b0;
  endtask

  task automatic do_read(input int port, input logic [31:0] a, input int lat);
    @(posedge clk);
    #1;
    sb_q.push_back('{port: port, data: word_of(a), cyc: cyc + lat});
    start_req(port, a);
    wait_ack(port);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0, m0, r0, n, c;
    bus.req = 2'b00; bus.addr0 = '0; bus.addr1 = '0;
    stall_beat = -1; stall_len = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ack", 32'(bus.ack), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    check("reset_mem_req", 32'(bus.mem_req), 32'd0);
    check("reset_mem_addr", bus.mem_addr, 32'd0);
`ifdef DMC_STATS_EN
    check("reset_hits", bus.hit_count, 32'd0);
    check("reset_misses", bus.miss_count, 32'd0);
`endif
    rst_n = 1'b1;

    // Cold miss, then a hit in the same line.
    r0 = n_refill; b0 = total_beats;
    mem_exp.push_back(32'h0000_1230);
    do_read(0, 32'h0000_1235, 20);
    check("cold_refills", 32'(n_refill - r0), 32'd1);
    check("cold_beats", 32'(total_beats - b0), 32'd16);
    m0 = mreq_cycles;
    do_read(0, 32'h0000_123A, 3);
    check("rehit_no_mem_req", 32'(mreq_cycles - m0), 32'd0);

    // Conflict eviction on index 0x23.
    mem_exp.push_back(32'h0000_2230);
    do_read(0, 32'h0000_2235, 20);
    mem_exp.push_back(32'h0000_1230);
    do_read(0, 32'h0000_1235, 20);
    check("conflict_refills", 32'(n_refill - r0), 32'd3);
`ifdef DMC_STATS_EN
    check("hit_count", bus.hit_count, 32'd1);
    check("miss_count", bus.miss_count, 32'd3);
`endif

    // Ties after reset: port0 first, then port1; repeat with hits.
    do_reset();
    @(posedge clk); #1;
    c = cyc;
    sb_q.push_back('{port: 0, data: word_of(32'h0000_1235), cyc: c + 20});
    sb_q.push_back('{port: 1, data: word_of(32'h0000_5552), cyc: c + 40});
    mem_exp.push_back(32'h0000_1230);
    mem_exp.push_back(32'h0000_5550);
    start_req(0, 32'h0000_1235);
    start_req(1, 32'h0000_5552);
    fork
      wait_ack(0);
      wait_ack(1);
    join
    @(posedge clk); #1;
    c = cyc;
    m0 = mreq_cycles;
    sb_q.push_back('{port: 0, data: word_of(32'h0000_1237), cyc: c + 3});
    sb_q.push_back('{port: 1, data: word_of(32'h0000_5559), cyc: c + 6});
    start_req(0, 32'h0000_1237);
    start_req(1, 32'h0000_5559);
    fork
      wait_ack(0);
      wait_ack(1);
    join
    check("tie_hits_no_mem_req", 32'(mreq_cycles - m0), 32'd0);

    // Reset after beat 7 of a refill.
    @(posedge clk); #1;
    b0 = total_beats;
    mem_exp.push_back(32'h0000_4560);
    start_req(0, 32'h0000_4567);
    n = 0;
    while (total_beats - b0 < 8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrefill_beats", 32'(total_beats - b0), 32'd8);
    rst_n = 1'b0;
    bus.req = 2'b00;
    #1;
    check("midrefill_mem_req_async", 32'(bus.mem_req), 32'd0);
    check("midrefill_mem_addr", bus.mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    b0 = total_beats;
    mem_exp.push_back(32'h0000_4560);
    do_read(0, 32'h0000_4567, 20);
    check("retry_beats", 32'(total_beats - b0), 32'd16);

    // Three-cycle gap between beats 4 and 5.
    stall_beat = 5; stall_len = 3;
    b0 = total_beats;
    mem_exp.push_back(32'h0000_7890);
    do_read(1, 32'h0000_789B, 23);
    check("stall_beats", 32'(total_beats - b0), 32'd16);
    stall_beat = -1;
    do_read(1, 32'h0000_7893, 3);
    do_read(0, 32'h0000_789F, 3);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("mem_exp_drained", 32'(mem_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_cache_ctrl.md
# dm_cache_ctrl

Read-only direct-mapped cache controller that shares one 256-line × 16-word cache between two requesters (port 0 and port 1). It arbitrates between them round-robin, performs tag lookup, runs a 16-beat burst refill from backing memory on a miss, and returns the requested word. Hit and miss statistics are optional. It sits between the fetch/load requesters and the memory interface, in place of free-running lookup logic.

## Interface
- `INDEX_W`, default 8: index bits. Sets the line count to 2^INDEX_W.
- `OFFSET_W`, default 4: word-offset bits. Sets the words per line to 2^OFFSET_W.
- `clk` input, 1: single clock. All state changes on the rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `req[1:0]` input, 2: request per port.
- `addr0`, `addr1` input, 32: word address per port. Fields are tag [31:12], index [11:4], offset [3:0].
- `ack[1:0]` output, 2: one-cycle response strobe per port.
- `rdata` output, 32: returned word. Valid only while an `ack` bit is high.
- `mem_req` output, 1: refill burst request.
- `mem_addr` output, 32: line base address, {tag, index, 4'b0}.
- `mem_valid` input, 1: refill beat valid.
- `mem_rdata` input, 32: refill beat data.
- `hit_count`, `miss_count` output, 32 each: statistics. Present only with `DMC_STATS_EN` defined.

## Operation
- Storage:
  - Data RAM: 256 × 16 × 32.
  - Tag RAM: 256 × 20.
  - Valid bits: 256, held in flops. All cleared by reset.
- FSM states: IDLE, LOOKUP, REFILL, RESP.
- IDLE:
  - If any `req` bit is high, grant one port, latch its address and port id, and go to LOOKUP.
  - Arbitration is round-robin. If both ports request, the port not granted last wins. After reset, `last_grant` is 1, so port 0 wins the first tie.
- LOOKUP:
  - Hit when valid[index] is set and tag[index] equals the latched tag.
  - Hit: increment `hit_count` and go to RESP.
  - Miss: increment `miss_count` and go to REFILL.
- REFILL:
  - Hold `mem_req` high and `mem_addr` stable.
  - Each `mem_valid` beat writes `mem_rdata` into word `beat_cnt`, then increments the 4-bit `beat_cnt`.
  - On beat 15: write the tag, set the valid bit, drop `mem_req` on the next cycle, and go to RESP.
- RESP:
  - Assert `ack[granted]` for exactly one cycle with `rdata` = data[index][offset].
  - Update `last_grant`, then return to IDLE.
- Requester rules:
  - Hold `req` and `addr` stable until its `ack`.
  - Deassert `req` in the cycle after `ack`. If `req` is still high, it is treated as a new request.
- No writes and no dirty state. Eviction is a plain overwrite of the line.
- `mem_valid` outside REFILL is ignored.
- Counters wrap modulo 2^32.

## Timing
- Reset values:
  - Outputs: `ack`=0, `rdata`=0, `mem_req`=0, `mem_addr`=0, counters=0.
  - Internal: FSM=IDLE, `beat_cnt`=0, `last_grant`=1.
- Hit latency, with `req` sampled at edge N:
  - LOOKUP in cycle N+1.
  - `ack` high in cycle N+2, after edge N+2.
  - Back-to-back throughput: one hit per 3 cycles.
- Miss latency:
  - `mem_req` rises after edge N+2.
  - `ack` comes one cycle after the edge that samples the 16th beat.
  - With zero-wait memory: `ack` in cycle N+19.
- `mem_valid` may stall (gap) at any beat. The FSM waits, with no timeout.
- Reset mid-refill:
  - `mem_req` drops asynchronously and the beat count is discarded.
  - The line stays invalid because valid bits are cleared.
  - The memory side must abandon the burst.
- A request arriving during LOOKUP, REFILL or RESP waits in IDLE arbitration. It is not lost as long as `req` is held.

## Configuration
- `DMC_STATS_EN`:
  - Defined: `hit_count` and `miss_count` ports and counters exist and count per lookup.
  - Undefined: the ports and counters are absent. FSM behaviour and timing are identical.

## Test plan
- Cold miss: reset, port0 reads 0x0000_1235, memory returns beats 0xA0..0xAF with zero wait. Required: `mem_addr`=0x0000_1230, `ack[0]` with `rdata`=0xA5, `miss_count`=1.
- Re-hit: port0 reads 0x0000_123A. Required: no `mem_req`, `ack[0]` two cycles after `req` with `rdata`=0xAA, `hit_count`=1.
- Conflict eviction: read 0x0000_2235 (same index 0x23, tag 2). Required: a miss and refill. Then read 0x0000_1235: another miss, `miss_count`=3.
- Simultaneous requests: both ports request hits on the same edge after reset. Required: port0 acked first, then port1. Repeating the tie grants port0 then port1 again, following round-robin.
- Reset mid-refill: assert `rst_n`=0 after beat 7. Required: `mem_req` immediately 0. After release, the same address misses again with a full 16 beats.
- Stalled refill: insert 3 idle cycles between beats 4 and 5. Required: correct data is returned and `ack` is delayed by exactly 3 cycles.
